// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch slice.
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; occupancy is counted separately so full and empty
// are unambiguous with naturally wrapping pointers.
module fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      // A same-cycle pop is already consumed by the reader; just drop the rest.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch sequencer: owns the fetch PC, drives the ROM address and buffers
// {pc, inst} entries for decode; redirects flush and re-target.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPc,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            rom_adr,
  input  logic [31:0]            rom_inst,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         push, pop;
  fetch_entry_t wentry, hentry;

  always_comb begin
    pop        = out_valid & out_ready;
    // Full is fine when the head leaves in the same cycle.
    push       = fetch_en & ~redirect_valid & ((out_count < CntW'(DEPTH)) | pop);
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    else if (push)      fetch_pc_d = fetch_pc_q + 32'd4;
    wentry.pc   = fetch_pc_q;
    wentry.inst = rom_inst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fetch_pc_q <= {RESET_PC[31:2], 2'b00};
    else        fetch_pc_q <= fetch_pc_d;
  end

  fetch_fifo #(
    .Depth (DEPTH),
    .Width ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (hentry),
    .count_o (out_count)
  );

  assign rom_adr   = fetch_pc_q;
  assign out_valid = (out_count != '0);
  assign out_pc    = hentry.pc;
  assign out_inst  = hentry.inst;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a combinational ROM model.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_adr, rom_inst;
  logic        fetch_en, redirect_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, out_pc, out_inst;
  logic [2:0]  out_count;
  int          checks = 0;
  int          errors = 0;

  ifetch_prefetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_adr        (rom_adr),
    .rom_inst       (rom_inst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] adr);
    return 32'h1000_0000 + {2'b00, adr[31:2]};
  endfunction

  assign rom_inst = word_at(rom_adr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, word_at(pc));
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_adr", rom_adr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);

    // Streaming: one entry per cycle, no gaps.
    rst_n = 1'b1;
    step();
    head("strm0", 32'h0);
    chk("strm0_count", 32'(out_count), 32'd1);
    for (int i = 1; i < 7; i++) begin
      step();
      head("strm", 32'(4 * i));
      chk("strm_count", 32'(out_count), 32'd1);
    end

    // Backpressure from a fresh reset.
    rst_n = 1'b0; step();
    rst_n = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_count4", 32'(out_count), 32'd4);
    chk("bp_adr4", rom_adr, 32'h10);
    for (int i = 0; i < 6; i++) step();
    chk("bp_count10", 32'(out_count), 32'd4);
    chk("bp_adr10", rom_adr, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      head("bp_rel", 32'(4 * i));
      step();
      chk("bp_full_count", 32'(out_count), 32'd4);
    end

    // Redirect while full: head is taken, one bubble, then target.
    rst_n = 1'b0; step();
    rst_n = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rf_count", 32'(out_count), 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; out_ready = 1'b1;
    head("rf_head", 32'h0);
    step();
    redirect_valid = 1'b0;
    chk("rf_bubble_valid", 32'(out_valid), 32'd0);
    chk("rf_bubble_count", 32'(out_count), 32'd0);
    chk("rf_bubble_adr", rom_adr, 32'h100);
    step();
    head("rf_tgt", 32'h100);

    // Address wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step(); head("wrap0", 32'hFFFF_FFF8);
    step(); head("wrap1", 32'hFFFF_FFFC);
    step(); head("wrap2", 32'h0000_0000);

    // fetch_en gating with two entries queued.
    redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("fe_count", 32'(out_count), 32'd2);
    fetch_en = 1'b0; out_ready = 1'b1;
    head("fe_h0", 32'h200);
    step();
    head("fe_h1", 32'h204);
    chk("fe_adr1", rom_adr, 32'h208);
    step();
    chk("fe_empty", 32'(out_valid), 32'd0);
    chk("fe_adr2", rom_adr, 32'h208);
    step();
    chk("fe_empty2", 32'(out_valid), 32'd0);
    chk("fe_adr3", rom_adr, 32'h208);
    fetch_en = 1'b1;
    step();
    head("fe_resume", 32'h208);

    // Reset beats a simultaneous redirect.
    step();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_count", 32'(out_count), 32'd0);
    chk("mrst_adr", rom_adr, 32'h0);
    rst_n = 1'b1; redirect_valid = 1'b0;
    step();
    head("mrst_first", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
